// File: rtl/async_fifo_1clk.sv
// async_fifo_1clk: single-clock FIFO with the async_fifo data/flag interface
// Ports:
//   clk       in   sole clock, all state on the rising edge
//   rst_n     in   asynchronous active-low reset
//   data_in   in   write data, stored when a write is accepted
//   wr_en     in   write request, ignored while full
//   full      out  no free entry
//   data_out  out  registered read data, holds until the next accepted read
//   rd_en     in   read request, ignored while empty
//   empty     out  no stored entry
module async_fifo_1clk #(
    parameter int data_width = 8,
    parameter int add_width  = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [data_width-1:0] data_in,
    input  logic                  wr_en,
    output logic                  full,
    output logic [data_width-1:0] data_out,
    input  logic                  rd_en,
    output logic                  empty
);
    localparam int depth = 1 << add_width;
    localparam logic [add_width:0] ptr_one = 1;

    logic [data_width-1:0] mem [0:depth-1];
    logic [add_width:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [data_width-1:0] data_out_q, data_out_d;
    logic                  wr_acc, rd_acc;

    // Pointers carry an extra wrap bit so equal addresses can mean either empty or full.
    assign empty    = wr_ptr_q == rd_ptr_q;
    assign full     = (wr_ptr_q[add_width-1:0] == rd_ptr_q[add_width-1:0]) &&
                      (wr_ptr_q[add_width] != rd_ptr_q[add_width]);
    assign wr_acc   = wr_en && !full;
    assign rd_acc   = rd_en && !empty;
    assign data_out = data_out_q;

    always_comb begin
        wr_ptr_d   = wr_acc ? wr_ptr_q + ptr_one : wr_ptr_q;
        rd_ptr_d   = rd_acc ? rd_ptr_q + ptr_one : rd_ptr_q;
        data_out_d = rd_acc ? mem[rd_ptr_q[add_width-1:0]] : data_out_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            data_out_q <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            data_out_q <= data_out_d;
        end
    end

    // Storage is deliberately unreset; reads are gated by empty so stale words never surface.
    always_ff @(posedge clk) begin
        if (wr_acc) mem[wr_ptr_q[add_width-1:0]] <= data_in;
    end
endmodule

// File: tb/tb_async_fifo_1clk.sv
// tb_async_fifo_1clk: queue-model bench for async_fifo_1clk
module tb_async_fifo_1clk;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] data_in = '0;
    logic       wr_en = 1'b0;
    logic       rd_en = 1'b0;
    logic       full, empty;
    logic [7:0] data_out;

    int n_chk = 0;
    int n_fail = 0;

    logic [7:0] q[$];
    logic [7:0] exp_dout = '0;
    logic       chk_en = 1'b1;

    async_fifo_1clk #(.data_width(8), .add_width(4)) dut (
        .clk(clk), .rst_n(rst_n), .data_in(data_in), .wr_en(wr_en),
        .full(full), .data_out(data_out), .rd_en(rd_en), .empty(empty)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference: a 16-deep queue; acceptance decided from occupancy before the edge.
    always @(posedge clk) begin
        if (rst_n) begin
            automatic bit wa = wr_en && q.size() < 16;
            automatic bit ra = rd_en && q.size() > 0;
            if (ra) exp_dout = q.pop_front();
            if (wa) q.push_back(data_in);
        end
    end

    always @(negedge rst_n) begin
        q.delete();
        exp_dout = '0;
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("empty", 32'(empty), 32'(q.size() == 0));
            chk("full", 32'(full), 32'(q.size() == 16));
            chk("data_out", 32'(data_out), 32'(exp_dout));
        end
    end

    task automatic cyc(input logic w, input logic r, input logic [7:0] d);
        wr_en = w;
        rd_en = r;
        data_in = d;
        @(posedge clk);
        #1;
    endtask

    initial begin
        cyc(1'b1, 1'b1, 8'h3C);
        cyc(1'b1, 1'b1, 8'h3C);
        chk("rst_empty", 32'(empty), 32'd1);
        chk("rst_full", 32'(full), 32'd0);
        chk("rst_dout", 32'(data_out), 32'd0);
        rst_n = 1'b1;

        for (int i = 1; i <= 20; i++) begin
            cyc(1'b1, 1'b0, 8'(i));
            chk("fill_full", 32'(full), 32'(i >= 16));
            chk("fill_empty", 32'(empty), 32'd0);
        end
        for (int i = 1; i <= 20; i++) begin
            cyc(1'b0, 1'b1, 8'h00);
            chk("drain_dout", 32'(data_out), 32'(i < 16 ? i : 16));
            chk("drain_empty", 32'(empty), 32'(i >= 16));
        end

        for (int i = 0; i < 10; i++) cyc(1'b1, 1'b0, 8'(8'h50 + i));
        for (int i = 0; i < 10; i++) cyc(1'b0, 1'b1, 8'h00);
        chk("pre_wrap_dout", 32'(data_out), 32'h59);
        for (int i = 0; i < 16; i++) cyc(1'b1, 1'b0, 8'(8'hA0 + i));
        chk("wrap_full", 32'(full), 32'd1);
        for (int i = 0; i < 16; i++) begin
            cyc(1'b0, 1'b1, 8'h00);
            chk("wrap_dout", 32'(data_out), 32'(8'hA0 + i));
        end
        chk("wrap_empty", 32'(empty), 32'd1);

        for (int i = 0; i < 16; i++) cyc(1'b1, 1'b0, 8'(8'h10 + i));
        cyc(1'b1, 1'b1, 8'h55);
        chk("both_full_dout", 32'(data_out), 32'h10);
        chk("both_full_flag", 32'(full), 32'd0);
        for (int i = 0; i < 15; i++) cyc(1'b0, 1'b1, 8'h00);
        chk("both_full_last", 32'(data_out), 32'h1F);
        chk("both_full_empty", 32'(empty), 32'd1);

        for (int i = 0; i < 5; i++) cyc(1'b1, 1'b0, 8'(8'hB0 + i));
        for (int i = 0; i < 8; i++) begin
            cyc(1'b1, 1'b1, 8'(8'hC0 + i));
            chk("both_mid_empty", 32'(empty), 32'd0);
            chk("both_mid_full", 32'(full), 32'd0);
        end
        chk("both_mid_dout", 32'(data_out), 32'hC2);

        cyc(1'b1, 1'b0, 8'hD0);
        cyc(1'b1, 1'b0, 8'hD1);
        wr_en = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_empty", 32'(empty), 32'd1);
        chk("mid_rst_full", 32'(full), 32'd0);
        chk("mid_rst_dout", 32'(data_out), 32'd0);
        rst_n = 1'b1;
        cyc(1'b1, 1'b0, 8'h77);
        cyc(1'b0, 1'b1, 8'h00);
        chk("post_rst_dout", 32'(data_out), 32'h77);
        chk("post_rst_empty", 32'(empty), 32'd1);

        for (int i = 0; i < 3000; i++) begin
            automatic int mode = (i / 500) % 3;
            automatic logic w = $urandom_range(0, 9) < (mode == 0 ? 7 : mode == 1 ? 3 : 5);
            automatic logic r = $urandom_range(0, 9) < (mode == 0 ? 3 : mode == 1 ? 7 : 5);
            cyc(w, r, 8'($urandom));
        end

        chk_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
